// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
// register_bank_pkg : shared defaults, clear-FSM states, zero-register index
// Rev 1.0
// ============================================================================
package register_bank_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  // Entry at this index is hardwired to zero
  localparam int RB_ZERO_IDX = 0;

  typedef enum logic [0:0] {
    RB_IDLE  = 1'b0,
    RB_CLEAR = 1'b1
  } rb_state_t;

endpackage : register_bank_pkg
`default_nettype wire

// File: rtl/register_bank_if.sv
`default_nettype none
// ============================================================================
// register_bank_if : write/read/clear bus of the register bank
// Rev 1.0
// ============================================================================
interface register_bank_if
  import register_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             clr_req;
  logic             busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    input  rd_data_a, rd_data_b, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    output rd_data_a, rd_data_b, busy
  );

endinterface : register_bank_if
`default_nettype wire

// File: rtl/register_bank_clr_seq.sv
`default_nettype none
// ============================================================================
// register_bank_clr_seq : sequenced clear engine, zeroes entries 1..DEPTH-1
// Rev 1.0
// ============================================================================
module register_bank_clr_seq
  import register_bank_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rb_state_t     state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state <= RB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RB_IDLE: begin
        // Entry 0 never needs clearing, so the sweep starts at 1
        if (clr_req) begin
          state_nxt = RB_CLEAR;
          cnt_nxt   = AW'(1);
        end
      end
      RB_CLEAR: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = RB_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: begin
        state_nxt = RB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == RB_CLEAR);
  assign clr_we   = (state == RB_CLEAR);
  assign clr_addr = cnt;

endmodule : register_bank_clr_seq
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// register_bank : DEPTH x WIDTH register file, 1 write / 2 registered reads
// Optional write-first forwarding: REGISTER_BANK_BYPASS_EN.  Rev 1.0
// ============================================================================
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            CLK,
  input  logic            reset_n,
  register_bank_if.slave  bus
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(RB_ZERO_IDX);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_accept;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  register_bank_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // The sweep only runs while busy, and user writes are dropped while busy,
  // so the two write sources never collide.
  assign wr_accept = bus.wr_en && !busy && (bus.wr_addr != ZERO_ADDR);
  assign we        = clr_we || wr_accept;
  assign waddr     = clr_we ? clr_addr : bus.wr_addr;
  assign wdata     = clr_we ? '0 : bus.wr_data;

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      rd_a <= (bus.rd_addr_a == ZERO_ADDR) ? '0 : mem[bus.rd_addr_a];
      rd_b <= (bus.rd_addr_b == ZERO_ADDR) ? '0 : mem[bus.rd_addr_b];
`ifdef REGISTER_BANK_BYPASS_EN
      if (wr_accept && (bus.wr_addr == bus.rd_addr_a)) rd_a <= bus.wr_data;
      if (wr_accept && (bus.wr_addr == bus.rd_addr_b)) rd_b <= bus.wr_data;
`endif
    end
  end

  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;
  assign bus.busy      = busy;

endmodule : register_bank
`default_nettype wire

// File: doc/register_bank.md
# register_bank

Parametrised multi-register storage block; the successor to the single 16-bit `register`. It holds `DEPTH` registers of `WIDTH` bits, with one synchronous write port and two registered read ports. A sequenced clear engine zeroes the bank one entry per cycle on request. It sits in the datapath as the general-purpose register file feeding the ALU operand latches.

## Interface
- `WIDTH`, 16, data width of each register.
- `DEPTH`, 16, number of registers; power of two, ≥2.
- `AW`, $clog2(DEPTH), address width (derived, not overridden).
- `CLK` input 1: rising-edge clock.
- `reset_n` input 1: synchronous, active-low reset; one clock, one synchronous active-low reset.
- `wr_en` input 1: write strobe.
- `wr_addr` input AW: write address.
- `wr_data` input WIDTH: write data.
- `rd_addr_a` input AW: read port A address.
- `rd_addr_b` input AW: read port B address.
- `rd_data_a` output WIDTH: registered read data A.
- `rd_data_b` output WIDTH: registered read data B.
- `clr_req` input 1: start a sequenced clear.
- `busy` output 1: clear in progress.

## Operation
- Storage array `mem[DEPTH]`. Entry 0 is hardwired to zero: writes to address 0 are dropped, and reads of address 0 return 0.
- Write: on a `CLK` edge with `wr_en=1`, `busy=0`, and `wr_addr≠0`, `mem[wr_addr] <= wr_data`.
- Read: on every edge, `rd_data_x <= mem[rd_addr_x]`. Reads are never blocked by `busy`; during a clear they return the current array contents.
- Clear FSM has two states:
  - IDLE→CLEAR when `clr_req=1`. The counter loads 1 and `busy` becomes 1.
  - In CLEAR, each cycle does `mem[cnt] <= 0` and `cnt++`.
  - CLEAR→IDLE after the cycle that clears `DEPTH-1`. The counter wraps to 0, and `busy` drops on the following edge.
- `clr_req` while `busy=1` is ignored; the sweep does not restart.
- `wr_en` while `busy=1` is dropped silently; no write occurs.
- `clr_req` and `wr_en` in the same IDLE cycle: the write to `wr_addr` is performed and the FSM enters CLEAR. The sweep later zeroes that entry.
- Reset (`reset_n=0` at an edge):
  - All `mem` entries, `rd_data_a`, and `rd_data_b` become 0.
  - FSM goes to IDLE, `busy=0`, counter 0.
  - Reset during CLEAR aborts the sweep; the array is zeroed anyway.

## Timing
- Write-to-array latency: 1 edge.
- Read latency: 1 edge from address to `rd_data_x`.
- Read-during-write to the same nonzero address in the same cycle returns the old value, unless `REGISTER_BANK_BYPASS_EN` is defined.
- A clear occupies `DEPTH-1` cycles with `busy=1`. `busy` asserts on the edge that samples `clr_req`.
- Reset values of all outputs are 0.

## Configuration
- Macro: `REGISTER_BANK_BYPASS_EN`.
- Defined: if `wr_en` is accepted and `wr_addr==rd_addr_x≠0`, then `rd_data_x <= wr_data` on that edge (write-first). Port A and port B are bypassed independently.
- Undefined: read-first behaviour. The old contents are returned, and there is no forwarding logic.
- No bypass from the clear sweep in either case.

## Structure
- Shared package `register_bank_pkg`:
  - default `WIDTH`/`DEPTH` constants;
  - clear FSM state enum `{RB_IDLE, RB_CLEAR}`;
  - the zero-register index constant.
- One sub-module `register_bank_clr_seq`: the FSM, counter, and `busy` logic, outputting `clr_we`/`clr_addr` into the bank write mux.
- Array and read ports stay in the top level.

## Test plan
- Reset, then read all addresses → every `rd_data` is 0x0000; `busy=0`.
- Write 0x8888 to addr 5, then read A=5 the next cycle → `rd_data_a=0x8888` one edge after the address is presented. Read B=5 → also 0x8888.
- Write 0xFFFF to addr 0, then read addr 0 → 0x0000.
- Same-cycle write 0x1234 and read A=7 while addr 7 holds 0xAAAA:
  - bypass defined → 0x1234;
  - bypass undefined → 0xAAAA, with 0x1234 on the next read.
- Fill addrs 1..15 with nonzero values, then pulse `clr_req`:
  - `busy` is high for exactly 15 cycles;
  - a `wr_en` to addr 3 mid-sweep is dropped;
  - afterwards all addresses read 0.
- Start a clear, assert `reset_n=0` at cycle 4 → `busy=0` and all reads are 0 after the reset edge. A subsequent write to addr 2 of 0x0F0F reads back 0x0F0F.
